// File: rtl/ddr_clk_div_gen_pkg.sv
// ----------------------------------------------------------------------------
// ddr_clk_div_gen_pkg
//
// Shared definitions for the DDR-interpolated clock/reference generator.
// This package holds the FSM state type and the system-level constants.
// The top level reuses those constants to check the reference-output
// frequency. The package has no ports.
//
//   CORE_CLK_HZ  frequency of the fabric core clock that drives the generator
//   REF_OUT_DIV  divide ratio that turns the core clock into the 10 MHz ref out
//   state_e      generator state: idle, running, or finishing the last period
// ----------------------------------------------------------------------------
package ddr_clk_div_gen_pkg;

  localparam int CORE_CLK_HZ = 250000000;
  localparam int REF_OUT_DIV = 25;

  // The generator only ever stops on a period boundary. STOPPING is the
  // "enable has dropped but the current period must still complete" state.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

endpackage : ddr_clk_div_gen_pkg

// File: rtl/ddr_clk_div_gen.sv
// ----------------------------------------------------------------------------
// ddr_clk_div_gen
//
// Programmable clock/reference generator with 2 ns (half-cycle) resolution.
// The block drives the D0/D1 pair of an external ODDR2. D0 is the level for
// the rising-clk half and D1 is the level for the falling-clk half. Because of
// this, any integer divide N >= 2 produces an exact 50% duty cycle. For odd N,
// the falling edge of the output lands in the middle of a core-clock cycle.
// The ODDR2 and the output buffer live in the top level. This block is pure
// fabric logic.
//
// Ports
//   clk         in   250 MHz core clock (ODDR2 C0 = clk, C1 = ~clk)
//   rst_n       in   asynchronous reset, active low
//   enable      in   level request to run (1) or stop (0)
//   div_in      in   new divide ratio N (values below 2 are treated as 2)
//   div_load    in   one-cycle strobe: capture div_in into the pending ratio
//   d0          out  ODDR2 D0, output level for the first half-cycle
//   d1          out  ODDR2 D1, output level for the second half-cycle
//   sync        out  one-cycle strobe aligned with the period's rising edge
//   running     out  high while periods are being generated
//   div_active  out  divide ratio currently in effect
// ----------------------------------------------------------------------------
module ddr_clk_div_gen
  import ddr_clk_div_gen_pkg::*;
#(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = REF_OUT_DIV,
  parameter bit START_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 div_load,
  output logic                 d0,
  output logic                 d1,
  output logic                 sync,
  output logic                 running,
  output logic [DIV_WIDTH-1:0] div_active
);

  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_active_q, div_active_d;
  logic [DIV_WIDTH-1:0] pending_q, pending_d;
  logic                 d0_q, d0_d;
  logic                 d1_q, d1_d;
  logic                 sync_q, sync_d;

  logic [DIV_WIDTH-1:0] half_div;
  logic [DIV_WIDTH-1:0] last_cnt;
  logic                 active;
  logic                 wrap;

  // Period bookkeeping. last_cnt cannot underflow because the divide ratio is
  // never below 2. For the same reason, the largest ratio (all ones) still
  // gives a last_cnt that fits in the counter width.
  always_comb begin
    half_div = div_active_q >> 1;
    last_cnt = div_active_q - ONE;
    active   = (state_q != ST_IDLE);
    wrap     = active && (cnt_q == last_cnt);
  end

  // Pending ratio. A load always overwrites the previous one, so the last
  // load before a wrap is the one that takes effect. The wrap logic copies
  // pending_q (the value before this cycle's load). As a result, a load that
  // lands on the wrap cycle waits for the following wrap.
  always_comb begin
    pending_d = pending_q;
    if (div_load) begin
      pending_d = (div_in < MIN_DIV) ? MIN_DIV : div_in;
    end
  end

  // State, phase counter and active ratio.
  // - The ratio only changes on a wrap, so a period already in progress is
  //   never cut short or stretched.
  // - When enable drops exactly on the wrap cycle, the generator goes straight
  //   to IDLE. This avoids starting a new period that would only run to
  //   completion.
  // - In STOPPING, re-asserting enable simply resumes RUN. The counter keeps
  //   advancing throughout, so the output waveform has no discontinuity.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_active_d = div_active_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d        = '0;
        div_active_d = pending_q;
        if (enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = wrap ? '0 : cnt_q + ONE;
        if (wrap) begin
          div_active_d = pending_q;
        end
        if (!enable) begin
          state_d = wrap ? ST_IDLE : ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        cnt_d = wrap ? '0 : cnt_q + ONE;
        if (wrap) begin
          div_active_d = pending_q;
        end
        if (enable) begin
          state_d = ST_RUN;
        end else if (wrap) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output levels are registered one clock after the phase they describe.
  // With H = N/2:
  // - Even N: both halves are high for the first H phases.
  // - Odd N: D0 stays high for one extra phase (phase H), so the output falls
  //   at the middle of that cycle.
  // In both cases, the output is high for exactly N of the 2N half-cycles.
  always_comb begin
    d0_d   = 1'b0;
    d1_d   = 1'b0;
    sync_d = 1'b0;
    if (active) begin
      d1_d   = (cnt_q < half_div);
      d0_d   = div_active_q[0] ? (cnt_q <= half_div) : (cnt_q < half_div);
      sync_d = (cnt_q == '0);
    end
  end

  // A mid-period reset forces the outputs low immediately, which may leave a
  // runt pulse on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= START_EN ? ST_RUN : ST_IDLE;
      cnt_q        <= '0;
      div_active_q <= DEF_DIV;
      pending_q    <= DEF_DIV;
      d0_q         <= 1'b0;
      d1_q         <= 1'b0;
      sync_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_active_q <= div_active_d;
      pending_q    <= pending_d;
      d0_q         <= d0_d;
      d1_q         <= d1_d;
      sync_q       <= sync_d;
    end
  end

  assign d0         = d0_q;
  assign d1         = d1_q;
  assign sync       = sync_q;
  assign running    = (state_q != ST_IDLE);
  assign div_active = div_active_q;

endmodule : ddr_clk_div_gen

// File: tb/tb_ddr_clk_div_gen.sv
// ----------------------------------------------------------------------------
// tb_ddr_clk_div_gen
//
// Bench for the DDR clock/reference generator.
// - The reference model describes the waveform in half-cycle terms: phase p
//   of an N period has its D0 half-cycle high when 2p < N and its D1
//   half-cycle high when 2p+1 < N.
// - The model switches between generating and idle only on period boundaries,
//   based on the enable level sampled at that boundary.
// - Directed sequences record the DUT outputs. Those recordings are then
//   pinned against hand-derived literal waveforms.
// ----------------------------------------------------------------------------
module tb_ddr_clk_div_gen;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] div_in;
  logic       div_load;
  logic       d0;
  logic       d1;
  logic       sync;
  logic       running;
  logic [7:0] div_active;

  int checks;
  int errors;
  bit chk_en;

  ddr_clk_div_gen #(
    .DIV_WIDTH  (8),
    .DEFAULT_DIV(25),
    .START_EN   (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .div_in    (div_in),
    .div_load  (div_load),
    .d0        (d0),
    .d1        (d1),
    .sync      (sync),
    .running   (running),
    .div_active(div_active)
  );

  // 100 MHz bench clock; the DUT sees only edges, so the absolute rate is irrelevant.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  bit   m_active;
  int   m_phase;
  int   m_n;
  int   m_pend;
  bit   exp_d0;
  bit   exp_d1;
  bit   exp_sync;
  logic m_boundary;

  function automatic int clampDiv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  // A boundary is any idle cycle or the last phase of a generated period.
  assign m_boundary = !m_active || (m_phase == m_n - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b1;
      m_phase  <= 0;
      m_n      <= 25;
      m_pend   <= 25;
      exp_d0   <= 1'b0;
      exp_d1   <= 1'b0;
      exp_sync <= 1'b0;
    end else begin
      exp_d0   <= m_active && (2 * m_phase < m_n);
      exp_d1   <= m_active && (2 * m_phase + 1 < m_n);
      exp_sync <= m_active && (m_phase == 0);
      m_phase  <= m_boundary ? 0 : m_phase + 1;
      m_active <= m_boundary ? enable : m_active;
      m_n      <= m_boundary ? m_pend : m_n;
      m_pend   <= div_load ? clampDiv(int'(div_in)) : m_pend;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, compare the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model_d0", int'(d0), int'(exp_d0));
      checkOutput("model_d1", int'(d1), int'(exp_d1));
      checkOutput("model_sync", int'(sync), int'(exp_sync));
      checkOutput("model_running", int'(running), int'(m_active));
      checkOutput("model_div_active", int'(div_active), m_n);
    end
  end

  // Recording of the outputs seen after each stimulus cycle.
  int rec_d0[512];
  int rec_d1[512];
  int rec_sync[512];
  int rec_run[512];
  int rec_div[512];
  int rec_n;

  int pat_d0_n7[7] = '{1, 1, 1, 1, 0, 0, 0};
  int pat_d1_n7[7] = '{1, 1, 1, 0, 0, 0, 0};
  int pat_n4[4]    = '{1, 1, 0, 0};

  task automatic clearRec();
    rec_n = 0;
  endtask

  task automatic applyStimulus(input bit en, input bit ld, input int din);
    enable   = en;
    div_load = ld;
    div_in   = 8'(din);
    @(negedge clk);
    rec_d0[rec_n]   = int'(d0);
    rec_d1[rec_n]   = int'(d1);
    rec_sync[rec_n] = int'(sync);
    rec_run[rec_n]  = int'(running);
    rec_div[rec_n]  = int'(div_active);
    rec_n++;
  endtask

  function automatic int sumRange(input int sel, input int lo, input int hi);
    int s = 0;
    for (int i = lo; i <= hi; i++) begin
      case (sel)
        0: s += rec_d0[i];
        1: s += rec_d1[i];
        2: s += rec_sync[i];
        default: s += rec_run[i];
      endcase
    end
    return s;
  endfunction

  initial begin
    checks   = 0;
    errors   = 0;
    chk_en   = 1'b0;
    enable   = 1'b1;
    div_load = 1'b0;
    div_in   = 8'd0;
    rst_n    = 1'b1;
    rec_n    = 0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_d0", int'(d0), 0);
    checkOutput("rst_sync", int'(sync), 0);
    checkOutput("rst_running", int'(running), 1);
    checkOutput("rst_div_active", int'(div_active), 25);
    rst_n = 1'b1;

    // 1: free-running N=25 from reset
    $display("[TB] N=25 from reset");
    clearRec();
    repeat (50) applyStimulus(1, 0, 0);
    checkOutput("n25_d0_high", sumRange(0, 0, 24), 13);
    checkOutput("n25_d1_high", sumRange(1, 0, 24), 12);
    checkOutput("n25_d0_last_high", rec_d0[12], 1);
    checkOutput("n25_d0_first_low", rec_d0[13], 0);
    checkOutput("n25_d1_last_high", rec_d1[11], 1);
    checkOutput("n25_d1_first_low", rec_d1[12], 0);
    checkOutput("n25_sync_first", rec_sync[0], 1);
    checkOutput("n25_sync_second", rec_sync[25], 1);
    checkOutput("n25_sync_count", sumRange(2, 0, 49), 2);

    // 2: load 4 at phase 5 of an N=25 period
    $display("[TB] reload 4 mid-period");
    repeat (5) applyStimulus(1, 0, 0);
    clearRec();
    applyStimulus(1, 1, 4);
    repeat (26) applyStimulus(1, 0, 0);
    checkOutput("reload_div_before_wrap", rec_div[18], 25);
    checkOutput("reload_div_at_wrap", rec_div[19], 4);
    checkOutput("reload_old_tail_low", rec_d0[19], 0);
    checkOutput("reload_sync_new", rec_sync[20], 1);
    checkOutput("reload_sync_period4", rec_sync[24], 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("reload_n4_d0_%0d", i), rec_d0[20 + i], pat_n4[i]);
      checkOutput($sformatf("reload_n4_d1_%0d", i), rec_d1[20 + i], pat_n4[i]);
    end

    // 3: load 0 on the wrap cycle, then load 1; both clamp to 2
    $display("[TB] clamp to 2");
    clearRec();
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 1);
    repeat (10) applyStimulus(1, 0, 0);
    checkOutput("clamp_load_on_wrap_deferred", rec_div[0], 4);
    checkOutput("clamp_div_before_wrap", rec_div[3], 4);
    checkOutput("clamp_div_after_wrap", rec_div[4], 2);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("clamp_n2_d0_%0d", i), rec_d0[5 + i], (i % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("clamp_n2_d1_%0d", i), rec_d1[5 + i], (i % 2 == 0) ? 1 : 0);
    end

    // 4: N=7, enable drops at phase 3
    $display("[TB] N=7 stop");
    applyStimulus(1, 1, 7);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("stop_div7_loaded", int'(div_active), 7);
    clearRec();
    repeat (3) applyStimulus(1, 0, 0);
    repeat (12) applyStimulus(0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("stop_d0_%0d", i), rec_d0[i], pat_d0_n7[i]);
      checkOutput($sformatf("stop_d1_%0d", i), rec_d1[i], pat_d1_n7[i]);
    end
    checkOutput("stop_running_last_phase", rec_run[5], 1);
    checkOutput("stop_running_idle", rec_run[6], 0);
    checkOutput("stop_no_more_sync", sumRange(2, 1, 14), 0);
    checkOutput("stop_outputs_quiet", sumRange(0, 7, 14) + sumRange(1, 7, 14), 0);
    checkOutput("stop_idle_running", sumRange(3, 6, 14), 0);

    // 5: restart from idle, with enable glitching low within one period
    $display("[TB] N=7 enable glitch");
    clearRec();
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    repeat (11) applyStimulus(1, 0, 0);
    checkOutput("glitch_start_delay", rec_d0[0], 0);
    checkOutput("glitch_running_all", sumRange(3, 0, 15), 16);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("glitch_d0_%0d", i), rec_d0[1 + i], pat_d0_n7[i]);
      checkOutput($sformatf("glitch_d1_%0d", i), rec_d1[1 + i], pat_d1_n7[i]);
    end
    checkOutput("glitch_sync_first", rec_sync[1], 1);
    checkOutput("glitch_sync_next", rec_sync[8], 1);

    // 6: asynchronous reset mid-period, with a pending load that must be discarded
    $display("[TB] async reset");
    clearRec();
    applyStimulus(1, 1, 9);
    applyStimulus(1, 0, 0);
    checkOutput("arst_d0_high_before", rec_d0[1], 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_d0_low", int'(d0), 0);
    checkOutput("arst_d1_low", int'(d1), 0);
    checkOutput("arst_sync_low", int'(sync), 0);
    checkOutput("arst_div_default", int'(div_active), 25);
    @(negedge clk);
    rst_n = 1'b1;
    clearRec();
    repeat (30) applyStimulus(1, 0, 0);
    checkOutput("arst_restart_sync", rec_sync[0], 1);
    checkOutput("arst_restart_d0_high", sumRange(0, 0, 24), 13);
    checkOutput("arst_restart_sync_next", rec_sync[25], 1);
    checkOutput("arst_pending_discarded", rec_div[29], 25);

    // 7: largest legal ratio, N=255
    $display("[TB] N=255");
    clearRec();
    applyStimulus(1, 1, 255);
    repeat (299) applyStimulus(1, 0, 0);
    checkOutput("n255_sync_start", rec_sync[20], 1);
    checkOutput("n255_div", rec_div[20], 255);
    checkOutput("n255_d0_high", sumRange(0, 20, 274), 128);
    checkOutput("n255_d1_high", sumRange(1, 20, 274), 127);
    checkOutput("n255_sync_next", rec_sync[275], 1);
    checkOutput("n255_sync_count", sumRange(2, 20, 299), 2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ddr_clk_div_gen
